// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand sequencer:
//   - ALU opcode encodings (OP_ADD .. OP_SHL)
//   - is_legal_op(op)  : 1 when the ALU implements the opcode
//   - is_unary_op(op)  : 1 when the opcode only consumes Operand1
//   - state_t          : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;   // wide enough for settle windows of 0..15 cycles

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHR, OP_SHL: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_unary_op(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// REGS x 32-bit local register file with two asynchronous read ports and one
// synchronous write port. All registers clear asynchronously on rst_n low.
// Ports:
//   clk, rst_n          clock (rising edge) / async active-low clear
//   we, waddr, wdata    write port, applied at the rising edge
//   raddr_a / rdata_a   combinational read port A
//   raddr_b / rdata_b   combinational read port B
// ADDR_W must equal clog2(REGS); read addresses are then always in range.
// -----------------------------------------------------------------------------
module alu_regfile
  import alu_pkg::*;
#(
  parameter int REGS   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REGS];
  logic [REGS-1:0]   wsel;

  // One-hot write select per register.
  for (genvar gi = 0; gi < REGS; gi++) begin : g_wsel
    assign wsel[gi] = we && (waddr == ADDR_W'(gi));
  end

  // Asynchronous clear is required, so the array is held in flops rather than
  // mapped to a RAM primitive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (wsel[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Initiator side of the ALU operand/opcode interface. Accepts one command at a
// time over CmdValid/CmdReady, reads operands from a local register file,
// drives Operand1/Operand2/Opcode into an external combinational ALU, captures
// Result after WAIT_CYCLES extra settle cycles, writes it back to the
// destination register and returns a response over RspValid/RspReady.
// Ports:
//   Clk, Reset_n                 clock / async active-low reset
//   CmdValid, CmdReady           command handshake
//   CmdLoad, CmdOpcode, CmdDst,
//   CmdSrcA, CmdSrcB, CmdUseImm,
//   CmdImm                       command fields
//   Operand1, Operand2, Opcode   registered drive to the ALU
//   Result                       ALU output
//   RspValid, RspReady           response handshake
//   RspData, RspDst, RspErr      response fields
//   Busy                         FSM is not IDLE
// WAIT_CYCLES legal range is 0..15.
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int REGS        = 4,
  parameter int ADDR_W      = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdLoad,
  input  logic [3:0]        CmdOpcode,
  input  logic [ADDR_W-1:0] CmdDst,
  input  logic [ADDR_W-1:0] CmdSrcA,
  input  logic [ADDR_W-1:0] CmdSrcB,
  input  logic              CmdUseImm,
  input  logic [31:0]       CmdImm,
  output logic [31:0]       Operand1,
  output logic [31:0]       Operand2,
  output logic [3:0]        Opcode,
  input  logic [31:0]       Result,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [31:0]       RspData,
  output logic [ADDR_W-1:0] RspDst,
  output logic              RspErr,
  output logic              Busy
);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [31:0]         op1_reg, op1_next;
  logic [31:0]         op2_reg, op2_next;
  logic [3:0]          opc_reg, opc_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [31:0]         rsp_data_reg, rsp_data_next;
  logic [ADDR_W-1:0]   rsp_dst_reg, rsp_dst_next;
  logic                rsp_err_reg, rsp_err_next;

  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [31:0]         rf_wdata;
  logic [31:0]         rd_a;
  logic [31:0]         rd_b;
  logic                accept;

  alu_regfile #(
    .REGS   (REGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (CmdSrcA),
    .rdata_a (rd_a),
    .raddr_b (CmdSrcB),
    .rdata_b (rd_b)
  );

  // Ready is gated with Reset_n so it drops immediately while reset is held,
  // even though the state register already sits in IDLE.
  assign CmdReady = (state_reg == ST_IDLE) && Reset_n;
  assign accept   = CmdValid && CmdReady;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      opc_reg       <= OP_ADD;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_dst_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op1_reg       <= op1_next;
      op2_reg       <= op2_next;
      opc_reg       <= opc_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_dst_reg   <= rsp_dst_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    opc_next       = opc_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_dst_next   = rsp_dst_reg;
    rsp_err_next   = rsp_err_reg;
    // rsp_dst_reg doubles as the in-flight destination during ISSUE.
    rf_we          = 1'b0;
    rf_waddr       = rsp_dst_reg;
    rf_wdata       = Result;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          rsp_dst_next = CmdDst;
          if (CmdLoad) begin
            // Direct load bypasses the ALU entirely.
            rf_we          = 1'b1;
            rf_waddr       = CmdDst;
            rf_wdata       = CmdImm;
            rsp_data_next  = CmdImm;
            rsp_err_next   = 1'b0;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end else if (!is_legal_op(CmdOpcode)) begin
            // Dropped command: ALU drive and registers are left untouched.
            rsp_data_next  = '0;
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end else begin
            op1_next   = rd_a;
            op2_next   = is_unary_op(CmdOpcode) ? 32'd0
                       : (CmdUseImm ? CmdImm : rd_b);
            opc_next   = CmdOpcode;
            cnt_next   = CNT_W'(WAIT_CYCLES);
            state_next = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          rf_we          = 1'b1;
          rsp_data_next  = Result;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (RspReady) begin
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign Operand1 = op1_reg;
  assign Operand2 = op2_reg;
  assign Opcode   = opc_reg;
  assign RspValid = rsp_valid_reg;
  assign RspData  = rsp_data_reg;
  assign RspDst   = rsp_dst_reg;
  assign RspErr   = rsp_err_reg;
  assign Busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with a behavioural combinational ALU.
// Expected responses are queued when a command is accepted and popped when
// the response appears; ALU drive values are tracked in a shadow register set.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int W = 1;

  logic        Clk;
  logic        Reset_n;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdLoad;
  logic [3:0]  CmdOpcode;
  logic [1:0]  CmdDst;
  logic [1:0]  CmdSrcA;
  logic [1:0]  CmdSrcB;
  logic        CmdUseImm;
  logic [31:0] CmdImm;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [3:0]  Opcode;
  logic [31:0] Result;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic [1:0]  RspDst;
  logic        RspErr;
  logic        Busy;

  alu_op_sequencer #(
    .REGS        (4),
    .ADDR_W      (2),
    .WAIT_CYCLES (W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .CmdValid  (CmdValid),
    .CmdReady  (CmdReady),
    .CmdLoad   (CmdLoad),
    .CmdOpcode (CmdOpcode),
    .CmdDst    (CmdDst),
    .CmdSrcA   (CmdSrcA),
    .CmdSrcB   (CmdSrcB),
    .CmdUseImm (CmdUseImm),
    .CmdImm    (CmdImm),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Opcode    (Opcode),
    .Result    (Result),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspData   (RspData),
    .RspDst    (RspDst),
    .RspErr    (RspErr),
    .Busy      (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural ALU on the far side of the interface.
  always_comb begin
    Result = 32'd0;
    case (Opcode)
      4'b0000: Result = Operand1 + Operand2;
      4'b0001: Result = Operand1 - Operand2;
      4'b0010: Result = Operand1 * Operand2;
      4'b0011: Result = Operand1 & Operand2;
      4'b0100: Result = Operand1 | Operand2;
      4'b0110: Result = Operand1 ^ Operand2;
      4'b0111: Result = ~Operand1;
      4'b1000: Result = Operand1 >> 1;
      4'b1001: Result = Operand1 << 1;
      default: Result = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  dst;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [4];
  logic [31:0] last_op1;
  logic [31:0] last_op2;
  logic [3:0]  last_opc;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle. Returns at the falling edge
  // after the accept edge.
  task automatic issue(input logic load, input logic [3:0] op, input logic [1:0] dst,
                       input logic [1:0] a, input logic [1:0] b, input logic ui,
                       input logic [31:0] imm, input logic [31:0] exp_data);
    exp_t e;
    logic ill;
    logic unary;
    ill   = !load && !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9});
    unary = op inside {4'd7, 4'd8, 4'd9};
    chk("cmd_ready_idle", 32'(CmdReady), 32'd1);
    CmdLoad   = load;
    CmdOpcode = op;
    CmdDst    = dst;
    CmdSrcA   = a;
    CmdSrcB   = b;
    CmdUseImm = ui;
    CmdImm    = imm;
    CmdValid  = 1'b1;
    e.data = ill ? 32'd0 : exp_data;
    e.dst  = dst;
    e.err  = ill;
    e.lat  = (load || ill) ? 0 : W + 1;
    if (!load && !ill) begin
      last_op1 = mregs[a];
      last_op2 = unary ? 32'd0 : (ui ? imm : mregs[b]);
      last_opc = op;
    end
    if (!ill) mregs[dst] = exp_data;
    @(posedge Clk);
    sb.push_back(e);
    #1 CmdValid = 1'b0;
    @(negedge Clk);
    chk("busy_after_accept", 32'(Busy), 32'd1);
    chk("operand1", Operand1, last_op1);
    chk("operand2", Operand2, last_op2);
    chk("opcode", 32'(Opcode), 32'(last_opc));
  endtask

  // Waits for the response, checks it, optionally holds RspReady low for
  // `hold` cycles with CmdValid asserted, then completes the handshake.
  task automatic collect(input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (RspValid !== 1'b1 && lat < 20) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    e = sb.pop_front();
    chk("rsp_latency", lat, e.lat);
    chk("rsp_data", RspData, e.data);
    chk("rsp_dst", 32'(RspDst), 32'(e.dst));
    chk("rsp_err", 32'(RspErr), 32'(e.err));
    chk("cmd_ready_resp", 32'(CmdReady), 32'd0);
    for (int i = 0; i < hold; i++) begin
      CmdValid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk("hold_valid", 32'(RspValid), 32'd1);
      chk("hold_data", RspData, e.data);
      chk("hold_cmd_ready", 32'(CmdReady), 32'd0);
    end
    RspReady = 1'b1;
    @(posedge Clk);
    #1 RspReady = 1'b0;
    @(negedge Clk);
    chk("rsp_valid_clear", 32'(RspValid), 32'd0);
    chk("rsp_err_clear", 32'(RspErr), 32'd0);
    chk("idle_after_ack", 32'(Busy), 32'd0);
    $display("rsp dst=%0d data=%h err=%0d lat=%0d", e.dst, RspData, RspErr, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_operand1"}, Operand1, 32'd0);
    chk({tag, "_operand2"}, Operand2, 32'd0);
    chk({tag, "_opcode"}, 32'(Opcode), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(RspValid), 32'd0);
    chk({tag, "_rsp_data"}, RspData, 32'd0);
    chk({tag, "_rsp_dst"}, 32'(RspDst), 32'd0);
    chk({tag, "_rsp_err"}, 32'(RspErr), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(CmdReady), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    Reset_n   = 1'b1;
    CmdValid  = 1'b0;
    CmdLoad   = 1'b0;
    CmdOpcode = 4'd0;
    CmdDst    = 2'd0;
    CmdSrcA   = 2'd0;
    CmdSrcB   = 2'd0;
    CmdUseImm = 1'b0;
    CmdImm    = 32'd0;
    RspReady  = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
    last_op1 = 32'd0;
    last_op2 = 32'd0;
    last_opc = 4'd0;

    #2 Reset_n = 1'b0;
    @(negedge Clk);
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1: loads then add
    issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'd5, 32'd5);                collect(0);
    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 32'd3, 32'd3);                collect(0);
    issue(1'b0, 4'b0000, 2'd2, 2'd0, 2'd1, 1'b0, 32'd0, 32'd8);             collect(0);

    // 2: subtract wrap, multiply wrap with immediate
    issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);                collect(0);
    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 32'd1, 32'd1);                collect(0);
    issue(1'b0, 4'b0001, 2'd3, 2'd0, 2'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);     collect(0);
    issue(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 32'h0001_0000, 32'h0001_0000); collect(0);
    issue(1'b0, 4'b0010, 2'd3, 2'd2, 2'd0, 1'b1, 32'h0001_0000, 32'h0);     collect(0);

    // 3: illegal opcode leaves ALU drive and R1 alone
    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 32'd3, 32'd3);                collect(0);
    issue(1'b0, 4'b0101, 2'd1, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);             collect(0);
    issue(1'b0, 4'b0000, 2'd2, 2'd1, 2'd0, 1'b1, 32'd0, 32'd3);             collect(0);

    // 4: unary shifts with Dst == SrcA
    issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'h8000_0001, 32'h8000_0001); collect(0);
    issue(1'b0, 4'b1001, 2'd0, 2'd0, 2'd1, 1'b0, 32'd0, 32'h0000_0002);     collect(0);
    issue(1'b0, 4'b1000, 2'd0, 2'd0, 2'd1, 1'b0, 32'd0, 32'h0000_0001);     collect(0);

    // 5: response back-pressure with a pending command
    issue(1'b0, 4'b0110, 2'd3, 2'd0, 2'd1, 1'b0, 32'd0, 32'd2);             collect(5);
    issue(1'b0, 4'b0011, 2'd1, 2'd1, 2'd0, 1'b0, 32'd0, 32'd1);             collect(0);
    issue(1'b0, 4'b0111, 2'd2, 2'd0, 2'd0, 1'b0, 32'd0, 32'hFFFF_FFFE);     collect(0);
    issue(1'b0, 4'b0100, 2'd3, 2'd0, 2'd0, 1'b1, 32'h0000_00F0, 32'h0000_00F1); collect(0);

    // 6: reset during ISSUE aborts the command
    issue(1'b0, 4'b0000, 2'd0, 2'd0, 2'd1, 1'b0, 32'd0, 32'd2);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    void'(sb.pop_back());
    for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
    last_op1 = 32'd0;
    last_op2 = 32'd0;
    last_opc = 4'd0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("abort_no_rsp", 32'(RspValid), 32'd0);
    end
    issue(1'b0, 4'b0000, 2'd2, 2'd2, 2'd3, 1'b0, 32'd0, 32'd0);             collect(0);
    issue(1'b0, 4'b0100, 2'd3, 2'd0, 2'd1, 1'b0, 32'd0, 32'd0);             collect(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
